// File: rtl/scytale_decryption_pkg.sv
// Shared definitions for the scytale decryption block: FSM encoding,
// default end-of-message token and key-field positions inside the key word.
package scytale_decryption_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECRYPT = 2'd2
  } scy_state_t;

  localparam logic [7:0] START_TOKEN_DEFAULT = 8'hFA;

  // Field numbers inside the key word: key_N sits in the upper field.
  localparam int KEY_N_FIELD = 1;
  localparam int KEY_M_FIELD = 0;

  function automatic int key_field_lsb(input int field, input int key_width);
    return field * key_width;
  endfunction

endpackage

// File: rtl/scytale_decryption_addr_gen.sv
// Transpose index generator: walks row-major buffer positions column by column
// using only adds (idx += key_n down a column, idx = col+1 on column wrap).
module scytale_addr_gen #(
  parameter int KEY_WIDTH = 8,
  parameter int IDX_W     = 2 * KEY_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [KEY_WIDTH-1:0] key_n,
  input  logic [KEY_WIDTH-1:0] key_m,
  output logic [KEY_WIDTH-1:0] row,
  output logic [KEY_WIDTH-1:0] col,
  output logic [IDX_W-1:0]     idx,
  output logic                 done
);

  logic row_last;

  assign row_last = (row == key_m - KEY_WIDTH'(1));
  assign done     = row_last && (col == key_n - KEY_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
      idx <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
      idx <= '0;
    end else if (advance) begin
      if (row_last) begin
        row <= '0;
        col <= col + KEY_WIDTH'(1);
        idx <= IDX_W'(col) + IDX_W'(1);
      end else begin
        row <= row + KEY_WIDTH'(1);
        idx <= idx + IDX_W'(key_n);
      end
    end
  end

endmodule

// File: rtl/scytale_decryption.sv
// Scytale decryption: buffers characters until the end-of-message token, then
// emits the transposed text one character per cycle. Optional length check: SCYTALE_LEN_CHECK_EN.
module scytale_decryption
  import scytale_decryption_pkg::*;
#(
  parameter int                   D_WIDTH                = 8,
  parameter int                   KEY_WIDTH              = 8,
  parameter int                   MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0]   START_DECRYPTION_TOKEN = D_WIDTH'(START_TOKEN_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [D_WIDTH-1:0]     data_i,
  input  logic                   valid_i,
  input  logic [2*KEY_WIDTH-1:0] key,
  output logic                   busy,
  output logic [D_WIDTH-1:0]     data_o,
  output logic                   valid_o,
  output logic                   err_o,
  output scy_state_t             dbg_state
);

  // valid_i/data_i form a push-only input (no backpressure): a character is
  // taken on any rising edge with valid_i high outside DECRYPT; valid_o/data_o
  // is a push-only output stream with one character per cycle while busy.

  localparam int CNT_W = $clog2(MAX_NOF_CHARS + 1);
  localparam int IDX_W = 2 * KEY_WIDTH;
  localparam int N_LSB = key_field_lsb(KEY_N_FIELD, KEY_WIDTH);
  localparam int M_LSB = key_field_lsb(KEY_M_FIELD, KEY_WIDTH);

  scy_state_t state, state_nxt;

  logic [D_WIDTH-1:0]   buffer [MAX_NOF_CHARS];
  logic [CNT_W-1:0]     wr_cnt;
  logic [KEY_WIDTH-1:0] key_n_in, key_m_in, key_n_q, key_m_q;
  logic [KEY_WIDTH-1:0] row, col;
  logic [IDX_W-1:0]     idx;
  logic [D_WIDTH-1:0]   rd_data;
  logic                 done;
  logic                 is_token, store, start, clear_buf, len_err, advance;
  logic                 len_bad;

  assign key_n_in = key[N_LSB +: KEY_WIDTH];
  assign key_m_in = key[M_LSB +: KEY_WIDTH];
  assign is_token = valid_i && (data_i == START_DECRYPTION_TOKEN);

`ifdef SCYTALE_LEN_CHECK_EN
  assign len_bad = (IDX_W'(key_n_in) * IDX_W'(key_m_in)) != IDX_W'(wr_cnt);
`else
  assign len_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    store     = 1'b0;
    start     = 1'b0;
    clear_buf = 1'b0;
    len_err   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (is_token) begin
          // A token on an empty buffer is a no-op.
          if (wr_cnt != '0) begin
            if (key_n_in == '0 || key_m_in == '0) begin
              clear_buf = 1'b1;
              state_nxt = IDLE;
            end else if (len_bad) begin
              len_err   = 1'b1;
              clear_buf = 1'b1;
              state_nxt = IDLE;
            end else begin
              start     = 1'b1;
              state_nxt = DECRYPT;
            end
          end
        end else if (valid_i) begin
          store     = (wr_cnt < CNT_W'(MAX_NOF_CHARS));
          state_nxt = COLLECT;
        end
      end
      DECRYPT: begin
        advance = 1'b1;
        if (done) begin
          clear_buf = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            wr_cnt <= '0;
    else if (clear_buf) wr_cnt <= '0;
    else if (store)     wr_cnt <= wr_cnt + CNT_W'(1);
  end

  // Buffer contents survive reset; wr_cnt alone defines what is valid.
  always_ff @(posedge clk) begin
    if (store) buffer[wr_cnt] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_n_q <= '0;
      key_m_q <= '0;
    end else if (start) begin
      key_n_q <= key_n_in;
      key_m_q <= key_m_in;
    end
  end

  scytale_addr_gen #(
    .KEY_WIDTH (KEY_WIDTH),
    .IDX_W     (IDX_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .advance (advance),
    .key_n   (key_n_q),
    .key_m   (key_m_q),
    .row     (row),
    .col     (col),
    .idx     (idx),
    .done    (done)
  );

  // Positions past the received text read as zero padding.
  assign rd_data = (idx < IDX_W'(wr_cnt)) ? buffer[idx[CNT_W-1:0]] : '0;

  assign busy      = (state == DECRYPT);
  assign valid_o   = busy;
  assign data_o    = busy ? rd_data : '0;
  assign dbg_state = state;

`ifdef SCYTALE_LEN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_o <= 1'b0;
    else     err_o <= len_err;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_scytale_decryption.sv
// Directed bench for scytale_decryption with hand-computed expected streams.
module tb_scytale_decryption;
  import scytale_decryption_pkg::*;

  localparam logic [7:0] TOKEN = 8'hFA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic [15:0] key = '0;
  logic        busy, valid_o, err_o;
  logic [7:0]  data_o;
  scy_state_t  dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  scytale_decryption dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .key       (key),
    .busy      (busy),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .err_o     (err_o),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
  endtask

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Sends tx_q then the token; valid_i is left high on the token.
  task automatic send_msg(input logic [15:0] k);
    key = k;
    while (tx_q.size() > 0) begin
      @(negedge clk);
      data_i  = tx_q.pop_front();
      valid_i = 1'b1;
    end
    @(negedge clk);
    data_i  = TOKEN;
    valid_i = 1'b1;
  endtask

  // Expects n back-to-back outputs from the cycle after the token, then idle.
  task automatic run_stream(input int n, input logic noise);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      valid_i = noise;
      data_i  = 8'h5A;
      check("valid_o", valid_o, 1);
      check("busy", busy, 1);
      check("err_o", err_o, 0);
      check($sformatf("data_o[%0d]", k), data_o, exp_q.pop_front());
    end
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = '0;
    check("valid_o_end", valid_o, 0);
    check("busy_end", busy, 0);
    check("data_o_end", data_o, 0);
    check("state_end", 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_err", err_o, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    // Basic 3x2 message.
    load_str("ACEBDF");
    expect_str("ABCDEF");
    send_msg(16'h0302);
    run_stream(6, 1'b0);

    // Token as first character: nothing happens.
    send_msg(16'h0302);
    run_stream(0, 1'b0);

    // Overflow: 55 chars, only first 50 kept; output = idx+1, idx = (k%5)*10 + k/5.
    for (int i = 1; i <= 55; i++) tx_q.push_back(8'(i));
    for (int k = 0; k < 50; k++) exp_q.push_back(8'((k % 5) * 10 + (k / 5) + 1));
    send_msg(16'h0A05);
    run_stream(50, 1'b0);

    // Short message against a 3x2 key.
    load_str("ACEB");
`ifdef SCYTALE_LEN_CHECK_EN
    send_msg(16'h0302);
    @(negedge clk);
    valid_i = 1'b0;
    check("len_err_pulse", err_o, 1);
    check("len_err_valid", valid_o, 0);
    @(negedge clk);
    check("len_err_clear", err_o, 0);
    check("len_err_state", 32'(dbg_state), 32'(IDLE));
`else
    exp_q.push_back("A"); exp_q.push_back("B"); exp_q.push_back("C");
    exp_q.push_back(8'h00); exp_q.push_back("E"); exp_q.push_back(8'h00);
    send_msg(16'h0302);
    run_stream(6, 1'b0);
`endif

    // Zero key field discards the message.
    load_str("AB");
    send_msg(16'h0002);
    run_stream(0, 1'b0);

    // Reset on the third output cycle.
    load_str("ACEBDF");
    send_msg(16'h0302);
    @(negedge clk);
    valid_i = 1'b0;
    check("rst_mid_d0", data_o, "A");
    @(negedge clk);
    check("rst_mid_d1", data_o, "B");
    @(negedge clk);
    check("rst_mid_d2", data_o, "C");
    rst = 1'b1;
    #1;
    check("rst_mid_valid", valid_o, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_data", data_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_idle", valid_o, 0);

    // Message after reset with a 2x3 key.
    load_str("ADBECF");
    expect_str("ABCDEF");
    send_msg(16'h0203);
    run_stream(6, 1'b0);

    // Characters during busy are ignored.
    load_str("ACEBDF");
    expect_str("ABCDEF");
    send_msg(16'h0302);
    run_stream(6, 1'b1);
    load_str("XY");
    expect_str("XY");
    send_msg(16'h0201);
    run_stream(2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
